regfile_writeback_unit: RTL
===========================

Name: regfile_writeback_unit

Overview:
- Write-side driver for the 32x32 register file: owns the A3/WD3/WE3 write port and arbitrates between the single-cycle ALU result and long-latency LSU/multiplier returns.
- LSU returns are buffered in a small FIFO.
- A pending-destination scoreboard tells decode when a source register is not yet valid.
- Sits between execute/memory stages and the register file, in parallel with the asynchronous read ports.

Parameters:
- XLEN, 32, data width of write data.
- DEPTH, 4, LSU return FIFO entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  long-latency return valid
- lsu_ready  out  1  FIFO can accept a return
- lsu_rd  in  5  return destination register
- lsu_data  in  XLEN  return data
- issue_valid  in  1  long-latency op issued; mark issue_rd pending
- issue_rd  in  5  destination of the issued op
- q_rs1  in  5  decode source 1 query
- q_rs2  in  5  decode source 2 query
- rs1_busy  out  1  q_rs1 not yet readable from the register file
- rs2_busy  out  1  q_rs2 not yet readable from the register file
- rs1_fwd_valid  out  1  forward valid for q_rs1 (optional feature)
- rs1_fwd_data  out  XLEN  forward data for q_rs1
- rs2_fwd_valid  out  1  forward valid for q_rs2
- rs2_fwd_data  out  XLEN  forward data for q_rs2
- A3  out  5  register file write address (registered)
- WD3  out  XLEN  register file write data (registered)
- WE3  out  1  register file write enable (registered)
- fifo_count  out  $clog2(DEPTH+1)  LSU FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - A3=0, WD3=0, WE3=0.
  - FIFO empty, fifo_count=0.
  - All pending bits 0.
  - Pushes and issues are ignored while reset is asserted.
- Push:
  - lsu_ready = (fifo_count < DEPTH), combinational. It reads 1 out of reset.
  - A push occurs on lsu_valid && lsu_ready.
  - When the FIFO is full, lsu_ready=0 even if a pop occurs in the same cycle (no same-cycle full-bypass).
- Write-port arbitration at each posedge, one-cycle latency from input to A3/WD3/WE3:
  1. If alu_valid: A3<=alu_rd, WD3<=alu_data, WE3<=(alu_rd!=0). The FIFO does not pop.
  2. Else if the FIFO is non-empty: pop the head; A3<=head.rd, WD3<=head.data, WE3<=(head.rd!=0). An entry with rd 0 is consumed with no write.
  3. Else WE3<=0. A3/WD3 hold their last values.
- The ALU has strict priority. FIFO starvation under continuous alu_valid is permitted; upstream guarantees gaps.
- Simultaneous push and pop: count unchanged. Push to an empty FIFO is poppable the next cycle at the earliest.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. Occupancy is tracked by an explicit counter.
- Scoreboard, pending[31:0]:
  - pending[0] is hardwired 0.
  - issue_valid sets pending[issue_rd]; issue_rd=0 is ignored.
  - Popping a FIFO entry (path 2) clears pending[head.rd].
  - If a set and a clear target the same register in the same cycle, the set wins.
  - ALU writes never touch the scoreboard.
- Busy, without the optional feature:
  - rsN_busy = pending[q_rsN] || (WE3 && A3==q_rsN && q_rsN!=0).
  - The second term covers the write-port stage not yet committed to the array.
- Query of x0 is never busy.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - rsN_fwd_valid = WE3 && A3==q_rsN && q_rsN!=0, and rsN_fwd_data = WD3.
  - rsN_busy = pending[q_rsN] && !rsN_fwd_valid.
  - Decode takes the forward instead of stalling.
- Undefined: fwd_valid and fwd_data are tied 0; busy is as in Behaviour.

Test Plan:
- Reset, then idle: WE3=0, lsu_ready=1, fifo_count=0, rs1_busy=0 for q_rs1=5.
- alu_valid, rd=3, data=0xDEADBEEF: next cycle A3=3, WD3=0xDEADBEEF, WE3=1. With alu_rd=0: WE3=0.
- issue_valid rd=7, then q_rs1=7: rs1_busy=1. LSU return rd=7, data=0x12345678 with the ALU idle: popped the next cycle with WE3=1, A3=7. pending[7] clears; busy is 0 once WE3 drops (or fwd_valid=1 during that WE3 cycle with WB_BYPASS_EN).
- Push 4 returns (rd 1..4) while alu_valid is held high: fifo_count=4, lsu_ready=0. Deassert alu_valid: writes rd 1,2,3,4 in order on consecutive cycles; lsu_ready=1 after the first pop.
- Same cycle: issue_valid rd=9 and pop of the head with rd=9: pending[9] stays 1.
- Assert rst_n low mid-drain with fifo_count=2: WE3=0 immediately (asynchronous), fifo_count=0, all busy=0.

Source files
------------

// File: rtl/regfile_writeback_unit_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_unit_if
//   Bundles every non-clock/reset signal of regfile_writeback_unit.
//   master : the surrounding pipeline (execute/memory/decode) and register file
//   slave  : regfile_writeback_unit itself
//   Groups:
//     ALU result     alu_valid, alu_rd, alu_data
//     LSU return     lsu_valid, lsu_ready, lsu_rd, lsu_data
//     Issue marking  issue_valid, issue_rd
//     Decode query   q_rs1/q_rs2 -> rsN_busy, rsN_fwd_valid, rsN_fwd_data
//     Write port     A3, WD3, WE3 (registered)
//     Status         fifo_count
// -----------------------------------------------------------------------------
interface regfile_writeback_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            issue_valid;
  logic [4:0]      issue_rd;

  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rs1_fwd_valid;
  logic [XLEN-1:0] rs1_fwd_data;
  logic            rs2_fwd_valid;
  logic [XLEN-1:0] rs2_fwd_data;

  logic [4:0]      A3;
  logic [XLEN-1:0] WD3;
  logic            WE3;

  logic [CW-1:0]   fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_rd,
    output q_rs1, q_rs2,
    input  rs1_busy, rs2_busy, rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
    input  A3, WD3, WE3,
    input  fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_rd,
    input  q_rs1, q_rs2,
    output rs1_busy, rs2_busy, rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data,
    output A3, WD3, WE3,
    output fifo_count
  );
endinterface

// File: rtl/regfile_writeback_unit.sv
// -----------------------------------------------------------------------------
// regfile_writeback_unit
//   Write-side driver of the 32x32 register file. Arbitrates the single-cycle
//   ALU result (strict priority) against long-latency returns buffered in a
//   DEPTH-entry FIFO, drives the registered A3/WD3/WE3 write port and keeps a
//   pending-destination scoreboard for decode.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     wb     regfile_writeback_unit_if.slave (ALU, LSU return, issue, decode
//            query, write port, fifo_count)
//   Optional feature: define WB_BYPASS_EN to forward the write-port stage to
//   decode instead of reporting it as busy.
// -----------------------------------------------------------------------------
module regfile_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  regfile_writeback_unit_if.slave  wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     pending_r;
  logic [4:0]      a3_r;
  logic [XLEN-1:0] wd3_r;
  logic            we3_r;

  entry_t          head_s;
  logic            ready_s;
  logic            push_s;
  logic            pop_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     pending_nxt_s;
  logic            hit1_s;
  logic            hit2_s;

  // True when the write-port stage holds an uncommitted write to query register q.
  function automatic logic wr_hit(input logic [4:0] q, input logic we, input logic [4:0] a);
    return we && (a == q) && (q != 5'd0);
  endfunction

  // Full blocks pushes even if a pop happens this cycle: no same-cycle bypass.
  assign ready_s = (count_r < FULL_C);
  assign push_s  = wb.lsu_valid && ready_s;
  assign pop_s   = !wb.alu_valid && (count_r != {CW{1'b0}});
  assign head_s  = mem_r[rd_ptr_r];

  // Set wins over clear on the same register; x0 never pending.
  assign set_mask_s    = (wb.issue_valid && (wb.issue_rd != 5'd0)) ? (32'd1 << wb.issue_rd) : 32'd0;
  assign clr_mask_s    = pop_s ? (32'd1 << head_s.rd) : 32'd0;
  assign pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

  // LSU return FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{rd: 5'd0, data: {XLEN{1'b0}}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{rd: wb.lsu_rd, data: wb.lsu_data};
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
    end
  end

  // Explicit occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Registered write port: ALU first, then FIFO head; A3/WD3 hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3_r  <= 5'd0;
      wd3_r <= {XLEN{1'b0}};
      we3_r <= 1'b0;
    end else if (wb.alu_valid) begin
      a3_r  <= wb.alu_rd;
      wd3_r <= wb.alu_data;
      we3_r <= (wb.alu_rd != 5'd0);
    end else if (pop_s) begin
      a3_r  <= head_s.rd;
      wd3_r <= head_s.data;
      we3_r <= (head_s.rd != 5'd0);
    end else begin
      we3_r <= 1'b0;
    end
  end

  assign hit1_s = wr_hit(wb.q_rs1, we3_r, a3_r);
  assign hit2_s = wr_hit(wb.q_rs2, we3_r, a3_r);

`ifdef WB_BYPASS_EN
  assign wb.rs1_fwd_valid = hit1_s;
  assign wb.rs1_fwd_data  = wd3_r;
  assign wb.rs1_busy      = pending_r[wb.q_rs1] && !hit1_s;
  assign wb.rs2_fwd_valid = hit2_s;
  assign wb.rs2_fwd_data  = wd3_r;
  assign wb.rs2_busy      = pending_r[wb.q_rs2] && !hit2_s;
`else
  assign wb.rs1_fwd_valid = 1'b0;
  assign wb.rs1_fwd_data  = {XLEN{1'b0}};
  assign wb.rs1_busy      = pending_r[wb.q_rs1] || hit1_s;
  assign wb.rs2_fwd_valid = 1'b0;
  assign wb.rs2_fwd_data  = {XLEN{1'b0}};
  assign wb.rs2_busy      = pending_r[wb.q_rs2] || hit2_s;
`endif

  assign wb.lsu_ready  = ready_s;
  assign wb.fifo_count = count_r;
  assign wb.A3         = a3_r;
  assign wb.WD3        = wd3_r;
  assign wb.WE3        = we3_r;

endmodule
